// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: ID/EX/MEM status toward the controller and
// the PC / IF/ID / ID/EX / EX/MEM enables and flushes back to the datapath.
// Build option: HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ;
  // Hazard-detection inputs from the datapath
  logic [4:0] id_Rs;
  logic [4:0] id_Rt;
  logic       id_uses_Rt;
  logic       ex_MemtoReg;
  logic       ex_RegWrite;
  logic [4:0] ex_Rt;
  logic       mem_BranchTaken;

  // Sequencing controls back to the datapath
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exmem_flush;
  logic [1:0] state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
`endif

  // Datapath side
  modport master (
    output id_Rs, id_Rt, id_uses_Rt, ex_MemtoReg, ex_RegWrite, ex_Rt,
           mem_BranchTaken,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush, state
`ifdef HAZARD_PERF_CNT_EN
    , input stall_count, flush_count
`endif
  );

  // Controller side
  modport slave (
    input  id_Rs, id_Rt, id_uses_Rt, ex_MemtoReg, ex_RegWrite, ex_Rt,
           mem_BranchTaken,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush, state
`ifdef HAZARD_PERF_CNT_EN
    , output stall_count, flush_count
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Detects load-use hazards (ID vs. load in EX) and holds the front end for
// LOAD_STALL_CYCLES cycles; squashes wrong-path work on a taken branch in MEM.
// Priority each cycle: branch flush > stall > run. Controls are combinational
// from the registered state/counter and the current inputs.
// Build option: HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic         CLK,
  input  logic         RST_N,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Remaining STALL cycles after the detection cycle, minus one
  localparam logic [1:0] STALL_INIT =
    (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

  state_t     state_q, state_nxt;
  logic [1:0] cnt_q, cnt_nxt;
  logic       load_use;
  logic       pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c, exmem_flush_c;

  // Load in EX writing a register that the instruction in ID reads
  assign load_use = bus.ex_MemtoReg & bus.ex_RegWrite & (bus.ex_Rt != 5'd0) &
                    ((bus.ex_Rt == bus.id_Rs) |
                     (bus.id_uses_Rt & (bus.ex_Rt == bus.id_Rt)));

  // State and stall counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next state and pipeline controls
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    exmem_flush_c = 1'b0;

    if (bus.mem_BranchTaken) begin
      // Taken branch: load target, squash IF/ID, ID/EX, EX/MEM, drop any stall
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      exmem_flush_c = 1'b1;
      state_nxt     = S_FLUSH;
      cnt_nxt       = 2'd0;
    end else begin
      unique case (state_q)
        S_STALL: begin
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_bubble_c = 1'b1;
          if (cnt_q == 2'd0) begin
            state_nxt = S_RUN;
          end else begin
            cnt_nxt = cnt_q - 2'd1;
          end
        end
        S_FLUSH: begin
          // EX holds a bubble this cycle, so load_use cannot be genuine
          state_nxt = S_RUN;
        end
        default: begin
          // S_RUN; the unused code 3 behaves the same and recovers to RUN
          state_nxt = S_RUN;
          if (load_use) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = S_STALL;
              cnt_nxt   = STALL_INIT;
            end
          end
        end
      endcase
    end
  end

  // Reset holds the pipeline frozen and squashed
  assign bus.pc_en       = RST_N & pc_en_c;
  assign bus.ifid_en     = RST_N & ifid_en_c;
  assign bus.ifid_flush  = ~RST_N | ifid_flush_c;
  assign bus.idex_bubble = ~RST_N | idex_bubble_c;
  assign bus.exmem_flush = ~RST_N | exmem_flush_c;
  assign bus.state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of frozen-PC cycles and taken-branch flush cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.mem_BranchTaken && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core: decides each cycle whether PC, IF/ID and ID/EX advance, stall or flush.
- Detects load-use hazards between the instruction in ID and a load in EX, and holds the front end for a parameterised number of cycles.
- Squashes wrong-path instructions when a branch resolves taken in MEM.
- Drives the PC enable, the IF/ID enable/flush, the ID/EX bubble (zeroes all control fields) and the EX/MEM flush.

Parameters:
- LOAD_STALL_CYCLES, 1: cycles the front end is held per load-use hazard (1 with MEM->EX forwarding, 2 without); legal range 1..3.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- id_Rs  in  5  Rs field of the instruction in ID.
- id_Rt  in  5  Rt field of the instruction in ID.
- id_uses_Rt  in  1  instruction in ID reads Rt (R-type, beq, sw).
- ex_MemtoReg  in  1  ID/EX MemtoReg, i.e. a load is in EX.
- ex_RegWrite  in  1  ID/EX RegWrite.
- ex_Rt  in  5  ID/EX Rt (load destination).
- mem_BranchTaken  in  1  EX/MEM Branch AND Zero.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a nop.
- idex_bubble  out  1  ID/EX loads all control bits as 0.
- exmem_flush  out  1  EX/MEM loads all control bits as 0.
- state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.

Behaviour:
- load_use = ex_MemtoReg & ex_RegWrite & (ex_Rt != 0) & ((ex_Rt == id_Rs) | (id_uses_Rt & (ex_Rt == id_Rt))). This term is combinational.
- The FSM state and the stall counter cnt (2 bits) are registered.
- All outputs are combinational from the state, cnt and the inputs, so they act in the same cycle as detection.
- Reset, while RST_N = 0:
  - state = RUN, cnt = 0.
  - pc_en = 0, ifid_en = 0.
  - ifid_flush = 1, idex_bubble = 1, exmem_flush = 1.
  - Reset deassertion takes effect at the next CLK edge.
- Priority each cycle: branch flush > stall > run.
- Flush (mem_BranchTaken = 1, in any state):
  - pc_en = 1 (target loaded), ifid_flush = 1, idex_bubble = 1, exmem_flush = 1.
  - Next state is FLUSH; cnt is cleared, aborting any pending stall.
- RUN state:
  - No hazard: pc_en = 1, ifid_en = 1, all flush/bubble outputs = 0.
  - load_use: pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - If LOAD_STALL_CYCLES > 1, next state is STALL with cnt = LOAD_STALL_CYCLES-2; otherwise the state stays RUN.
- STALL state:
  - Outputs as in the RUN load_use case, regardless of the current load_use value.
  - cnt == 0: next state is RUN. Otherwise cnt decrements.
- FLUSH state, exactly one cycle:
  - Outputs as RUN no-hazard; load_use is ignored, because EX holds a bubble.
  - Next state is RUN.
  - A new mem_BranchTaken in this cycle takes the flush path again.
- A stall never spans a branch flush: a flush in STALL immediately returns the front end to running on the next state.
- Loads to $0 never stall.
- A back-to-back load-use chain gives an independent stall per load.
- No X propagation: unknown state codes (3) decode as RUN and transition to RUN.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_count [CNT_W-1:0] and flush_count [CNT_W-1:0]:
  - stall_count increments on every cycle with pc_en = 0 outside reset.
  - flush_count increments on every cycle with mem_BranchTaken = 1.
  - Both saturate at all-ones, are cleared by RST_N, and are registered, so they update one cycle after the event.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then release with no hazards for 5 cycles -> during reset pc_en = 0, ifid_flush = idex_bubble = exmem_flush = 1; afterwards pc_en = ifid_en = 1, all flushes 0, state = 0.
- LOAD_STALL_CYCLES = 1, ex_MemtoReg = ex_RegWrite = 1, ex_Rt = 8, id_Rs = 8 for one cycle -> exactly 1 cycle with pc_en = 0, idex_bubble = 1, state stays 0.
- LOAD_STALL_CYCLES = 2, same hazard, then inputs cleared -> stall held 2 cycles (state = 1 in the 2nd), then RUN.
- ex_Rt = 0 = id_Rs with a load in EX; also id_Rt = 9 = ex_Rt with id_uses_Rt = 0 -> no stall in either case.
- LOAD_STALL_CYCLES = 3, hazard, then mem_BranchTaken = 1 in the first STALL cycle -> that cycle has pc_en = 1 and all three flushes = 1; the next cycle is state = 2, then RUN with no residual stall.
- HAZARD_PERF_CNT_EN defined, CNT_W = 2, 5 stall cycles and 2 flush cycles -> stall_count = 3 (saturated), flush_count = 2.
